// File: rtl/cpu_sequencer_pkg.sv
// Shared types and constants for the CPU control sequencer.
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        FAULT  = 3'd6
    } seq_state_t;

    localparam logic ADDR_SEL_PC   = 1'b0;
    localparam logic ADDR_SEL_DATA = 1'b1;

    function automatic logic is_mem_op(input logic load, input logic store);
        return load | store;
    endfunction

endpackage

// File: rtl/cpu_sequencer_timeout.sv
// Bus-request watchdog: counts held request cycles, flags the last allowed one.
module seq_timeout_counter #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W      = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam int LAST_I = (LIMIT > 0) ? LIMIT - 1 : 0;
    localparam logic [W-1:0] LAST = LAST_I[W-1:0];

    logic [W-1:0] count;
    logic         at_last;

    // expired marks the final request cycle; the caller faults only if it also misses mem_ready
    assign at_last = (LIMIT != 0) && (count == LAST);
    assign expired = at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !at_last) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the 12-bit core.
//
// state  | meaning
// IDLE   | stopped, waiting for start
// FETCH  | instruction read from PC address
// DECODE | IR stable, choose EXEC or MEM
// EXEC   | ALU/branch/jump strobes, retire
// MEM    | data read or write at data address
// WB     | load result written to register file, retire
// FAULT  | bus timeout, held until reset
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int RETIRE_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                halt_req,
    input  logic                mem_ready,
    input  logic                jump_op,
    input  logic                branch_op,
    input  logic                load_imm,
    input  logic                reg_write_enable,
    input  logic                flag_write_enable,
    input  logic                mem_load,
    input  logic                mem_store,
    input  logic                mem_store_upper,
    input  logic                branch_cond,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mem_upper,
    output logic                mem_addr_sel,
    output logic                ir_load,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                reg_write,
    output logic                flag_write,
    output logic                busy,
    output logic                fault,
    output logic [2:0]          state,
    output logic [RETIRE_W-1:0] retired_count
);

    seq_state_t state_q, state_d;
    logic       retire;
    logic       wd_expired;
    logic       wd_clear;
    logic       wd_enable;

    assign wd_enable = mem_req & ~mem_ready;
    assign wd_clear  = ~mem_req | mem_ready;

    seq_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_upper    = 1'b0;
        mem_addr_sel = ADDR_SEL_PC;
        ir_load      = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        reg_write    = 1'b0;
        flag_write   = 1'b0;
        retire       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = DECODE;
                end else if (wd_expired) begin
                    state_d = FAULT;
                end
            end
            DECODE: begin
                state_d = is_mem_op(mem_load, mem_store) ? MEM : EXEC;
            end
            EXEC: begin
                // LI always targets a register even if the decoder leaves reg_write_enable low
                reg_write  = reg_write_enable | load_imm;
                flag_write = flag_write_enable;
                pc_load    = jump_op | (branch_op & branch_cond);
                retire     = 1'b1;
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = ADDR_SEL_DATA;
                mem_we       = mem_store;
                mem_upper    = mem_store & mem_store_upper;
                if (mem_ready) begin
                    if (mem_load) begin
                        state_d = WB;
                    end else begin
                        retire = 1'b1;
                    end
                end else if (wd_expired) begin
                    state_d = FAULT;
                end
            end
            WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
            end
        endcase

        if (retire) begin
            state_d = halt_req ? IDLE : FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_count <= '0;
        end else if (retire) begin
            retired_count <= retired_count + 1'b1;
        end
    end

    assign busy  = (state_q != IDLE) && (state_q != FAULT);
    assign fault = (state_q == FAULT);
    assign state = state_q;

endmodule
